sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO. It is the next-generation buffer between the verify-platform data generator and the AES-128 core.
- Generalises data width and depth.
- Uses the true full depth, with no wasted slot.
- Adds an occupancy count, programmable almost-full and almost-empty flags, a read-valid strobe, a synchronous flush, and sticky overflow/underflow error flags.
- Single clock domain, registered read data.

---
 rtl/sync_fifo_param.sv | 64 ++++++
 tb/tb_sync_fifo_param.sv | 95 +++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered read data, occupancy flags and sticky error flags
module sync_fifo_param #(
   parameter int DATA_W   = 128,
   parameter int ADDR_W   = 3,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_require,
   input  logic              out_require,
   input  logic              flush,
   input  logic              clr_err,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);
   localparam int DEPTH = 2 ** ADDR_W;
   logic [DATA_W-1:0] ram [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              wr_acc, rd_acc;
   assign rd_acc       = out_require & ~empty;
   assign wr_acc       = in_require & (~full | rd_acc);
   assign full         = count == (ADDR_W+1)'(DEPTH);
   assign empty        = count == '0;
   assign almost_full  = count >= (ADDR_W+1)'(AF_LEVEL);
   assign almost_empty = count <= (ADDR_W+1)'(AE_LEVEL);
   always_ff @(posedge clk)
      if (rst_n & ~flush & wr_acc) ram[wr_ptr] <= in_data;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         out_data  <= rd_acc ? ram[rd_ptr] : out_data;
         out_valid <= rd_acc;
         wr_ptr    <= wr_acc ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr    <= rd_acc ? rd_ptr + 1'b1 : rd_ptr;
         count     <= (wr_acc & ~rd_acc) ? count + 1'b1 : (rd_acc & ~wr_acc) ? count - 1'b1 : count;
         // a new error event wins over a coincident clear
         overflow  <= (overflow & ~clr_err) | (in_require & full & ~rd_acc);
         underflow <= (underflow & ~clr_err) | (out_require & empty);
      end
   end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized and directed checks of sync_fifo_param against a queue-based reference model
module tb_sync_fifo_param;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_require = 1'b0, out_require = 1'b0, flush = 1'b0, clr_err = 1'b0;
   logic [127:0] out_data;
   logic         out_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0]   count;
   int           checks = 0, failures = 0;
   logic [127:0] mq[$];
   logic [127:0] m_data = '0;
   logic         m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
   sync_fifo_param dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_require(in_require),
      .out_require(out_require), .flush(flush), .clr_err(clr_err),
      .out_data(out_data), .out_valid(out_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, act, exp);
      end
   endtask
   task automatic step(input logic w, input logic r, input logic [127:0] d, input logic fl, input logic ce);
      logic e, f, ra, wa;
      @(negedge clk);
      in_require = w; out_require = r; in_data = d; flush = fl; clr_err = ce;
      @(posedge clk);
      if (!rst_n) begin
         mq.delete(); m_data = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
      end else if (fl) begin
         mq.delete(); m_valid = 0; m_ovf = 0; m_udf = 0;
      end else begin
         e  = mq.size() == 0;
         f  = mq.size() == 8;
         ra = r && !e;
         wa = w && (!f || ra);
         m_ovf = (m_ovf && !ce) || (w && f && !ra);
         m_udf = (m_udf && !ce) || (r && e);
         m_valid = ra;
         if (ra) m_data = mq.pop_front();
         if (wa) mq.push_back(d);
      end
      #1;
      check("count", 128'(count), 128'(mq.size()));
      check("full", 128'(full), 128'(mq.size() == 8));
      check("empty", 128'(empty), 128'(mq.size() == 0));
      check("almost_full", 128'(almost_full), 128'(mq.size() >= 6));
      check("almost_empty", 128'(almost_empty), 128'(mq.size() <= 1));
      check("overflow", 128'(overflow), 128'(m_ovf));
      check("underflow", 128'(underflow), 128'(m_udf));
      check("out_valid", 128'(out_valid), 128'(m_valid));
      check("out_data", out_data, m_data);
   endtask
   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction
   initial begin
      step(0, 0, '0, 0, 0);
      step(1, 1, 128'h55, 0, 0);
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) step(1, 0, {120'hA5A5_0000_0000_0000_0000_0000_0000_00, 8'(i)}, 0, 0);
      step(1, 0, {120'hA5A5_0000_0000_0000_0000_0000_0000_00, 8'h09}, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 0);
      step(0, 1, '0, 0, 0);
      step(0, 0, '0, 0, 1);
      step(1, 1, 128'hAA, 0, 0);
      for (int i = 0; i < 7; i++) step(1, 0, rnd128(), 0, 0);
      step(1, 1, 128'hBEEF, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 0);
      step(0, 0, '0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         step(1, 0, rnd128(), 0, 0);
         step(0, 1, '0, 0, 0);
      end
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rnd128(), 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) == 0));
      step(0, 0, '0, 1, 0);
      for (int i = 0; i < 5; i++) step(1, 0, rnd128(), 0, 0);
      step(1, 0, 128'hDEAD, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, rnd128(), 0, 0);
      step(0, 1, '0, 0, 0);
      rst_n = 1'b0;
      step(1, 1, 128'hCAFE, 0, 0);
      rst_n = 1'b1;
      step(0, 1, '0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
